// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU front-end definitions: bus widths and the fetch FSM state encoding,
// reused by the fetch stage, decode and debug logic.
package instr_fetch_unit_pkg;

  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_DATA_W = 16;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t S_IDLE  = 3'd0;
  localparam fetch_state_t S_REQ   = 3'd1;
  localparam fetch_state_t S_WAIT  = 3'd2;
  localparam fetch_state_t S_HOLD  = 3'd3;
  localparam fetch_state_t S_DRAIN = 3'd4;

endpackage

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// Wait-cycle counter for the fetch stage: cleared on grant, counts while
// waiting for read data, flags the last permitted wait cycle.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fetch_timeout_ctr: TIMEOUT must be at least 1");
  end

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Asserted during the TIMEOUT-th consecutive wait cycle with no response.
  assign o_tc = i_enable && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding read to instruction memory, result
// held for decode until consumed, with branch-redirect flush and sticky error.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int DATA_W  = FETCH_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              fetch_err
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_err;

  logic w_accept;
  logic w_ctr_clear;
  logic w_ctr_en;
  logic w_timeout;
  logic w_stray;

  assign pc_ready    = !flush && ((r_state == S_IDLE) ||
                                  ((r_state == S_HOLD) && instr_ready));
  assign w_accept    = pc_valid && pc_ready;
  assign w_ctr_clear = (r_state == S_REQ) && mem_gnt;
  assign w_ctr_en    = (r_state == S_WAIT);
  // A response is only expected while waiting for it or draining a flushed one.
  assign w_stray     = mem_rvalid && (r_state inside {S_IDLE, S_REQ, S_HOLD});

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_ctr_clear),
    .i_enable (w_ctr_en),
    .o_tc     (w_timeout)
  );

  // NOTE: every register here uses <= so all branches read the pre-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) r_addr <= pc_in;
      if (w_stray)  r_err  <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_REQ;
        end
        S_REQ: begin
          if (flush) begin
            r_state <= mem_gnt ? S_DRAIN : S_IDLE;
          end else if (mem_gnt) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            r_state <= mem_rvalid ? S_IDLE : S_DRAIN;
          end else if (mem_rvalid) begin
            r_instr    <= mem_rdata;
            r_instr_pc <= r_addr;
            r_state    <= S_HOLD;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (instr_ready) begin
            r_state <= w_accept ? S_REQ : S_IDLE;
          end
        end
        S_DRAIN: begin
          // The abandoned response must still be absorbed before a new request.
          if (mem_rvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req     = (r_state == S_REQ);
  assign mem_addr    = r_addr;
  assign instr_valid = (r_state == S_HOLD);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fetch_err   = r_err;

endmodule
